// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_pkg
// Brief  : Shared 7-segment constants and helpers for display drivers.
// Rev    : 1.0  initial release
// ============================================================================
package led_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segment patterns, seg[6]=a ... seg[0]=g, indexed by hex value.
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic int bright_limit(input int slot_cycles, input int guard);
        return slot_cycles - guard;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module : seg7_hex_decoder
// Brief  : Combinational hex nibble to active-low 7-segment pattern.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_hex_decoder
    import led_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[hex];
    end

endmodule
`default_nettype wire

// File: rtl/multi_digit_led_driver.sv
`default_nettype none
// ============================================================================
// Module : multi_digit_led_driver
// Brief  : Time-multiplexed N-digit common-anode 7-segment driver with guard
//          gap, PWM brightness, decimal points, blanking and frame buffering.
// Rev    : 2.0  parametrised generation of the 4-digit driver
// ============================================================================
module multi_digit_led_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 16,
    parameter int GUARD       = 2,
    parameter int BW          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   word,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [BW-1:0]             bright,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int              TW         = $clog2(SLOT_CYCLES);
    localparam int              DW         = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(SLOT_CYCLES - 1);
    localparam logic [DW-1:0]   DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0]   BRIGHT_MAX = BW'(bright_limit(SLOT_CYCLES, GUARD));
    localparam logic [31:0]     GUARD_U    = 32'(GUARD);

    logic [TW-1:0]           tick_q, tick_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] shadow_word_q, shadow_word_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [BW-1:0]           bright_slot_q, bright_slot_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_start_q, frame_start_d;

    logic                    frame_load;
    logic                    active;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    seg7_hex_decoder u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        digit_d = digit_q;
        if (tick_q == TICK_LAST) begin
            digit_d = (digit_q == '0) ? DIGIT_LAST : digit_q - 1'b1;
        end

        // Shadow registers only change at the frame boundary so a frame never tears.
        frame_load     = (digit_q == DIGIT_LAST) && (tick_q == '0);
        shadow_word_d  = frame_load ? word  : shadow_word_q;
        shadow_dp_d    = frame_load ? dp_in : shadow_dp_q;
        shadow_blank_d = frame_load ? blank : shadow_blank_q;
        frame_start_d  = frame_load;

        bright_slot_d = bright_slot_q;
        if (tick_q == '0) begin
            bright_slot_d = (bright > BRIGHT_MAX) ? BRIGHT_MAX : bright;
        end

        nibble = shadow_word_q[{digit_q, 2'b00} +: 4];
        active = (32'(tick_q) >= GUARD_U)
              && ((32'(tick_q) - GUARD_U) < 32'(bright_slot_q))
              && !shadow_blank_q[digit_q];

        an_d  = active ? ~(NUM_DIGITS'(1) << digit_q) : '1;
        seg_d = active ? dec_seg : SEG_OFF;
        dp_d  = active ? ~shadow_dp_q[digit_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q         <= '0;
            digit_q        <= DIGIT_LAST;
            shadow_word_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            bright_slot_q  <= '0;
            an_q           <= '1;
            seg_q          <= SEG_OFF;
            dp_q           <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            tick_q         <= tick_d;
            digit_q        <= digit_d;
            shadow_word_q  <= shadow_word_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            bright_slot_q  <= bright_slot_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_led_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_digit_led_driver
// Brief  : Scoreboard bench for multi_digit_led_driver (N=4, 16-cycle slots).
// Rev    : 1.0  initial release
// ============================================================================
module tb_multi_digit_led_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] word;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  bright;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } cyc_exp_t;

    typedef struct {
        int         last;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         lit;
    } slot_exp_t;

    cyc_exp_t  cq[$];
    slot_exp_t sq[$];
    cyc_exp_t  ce;
    int        acc_low  = 0;
    int        acc_good = 0;

    logic [6:0] tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    multi_digit_led_driver #(
        .NUM_DIGITS  (4),
        .SLOT_CYCLES (16),
        .GUARD       (2),
        .BW          (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .word        (word),
        .dp_in       (dp_in),
        .blank       (blank),
        .bright      (bright),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: per-cycle expectations, per-slot lit counts, single-anode rule.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d an=%b required at most one low", cyc, an);
            end
            if (cq.size() > 0 && cq[0].cyc < cyc) begin
                ce = cq.pop_front();
                errors++;
                $display("FAIL missed cyc=%0d expectation for cycle %0d never checked", cyc, ce.cyc);
            end else if (cq.size() > 0 && cq[0].cyc == cyc) begin
                ce = cq.pop_front();
                checks++;
                if (an !== ce.an || seg !== ce.seg || dp !== ce.dp || frame_start !== ce.fs) begin
                    errors++;
                    $display("FAIL cycle cyc=%0d got an=%b seg=%h dp=%b fs=%b required an=%b seg=%h dp=%b fs=%b",
                             cyc, an, seg, dp, frame_start, ce.an, ce.seg, ce.dp, ce.fs);
                end
            end
            if (sq.size() > 0 && cyc > sq[0].last - 16 && cyc <= sq[0].last) begin
                if (an !== 4'hF) acc_low++;
                if (an === sq[0].an && seg === sq[0].seg && dp === sq[0].dp) acc_good++;
                if (cyc == sq[0].last) begin
                    checks++;
                    if (acc_low != sq[0].lit || acc_good != sq[0].lit) begin
                        errors++;
                        $display("FAIL slot end=%0d an=%b got low=%0d good=%0d required lit=%0d",
                                 sq[0].last, sq[0].an, acc_low, acc_good, sq[0].lit);
                    end
                    void'(sq.pop_front());
                    acc_low  = 0;
                    acc_good = 0;
                end
            end
        end
    end

    task automatic exp_slot(input int first, input int lit, input logic [3:0] an_v,
                            input logic [6:0] seg_v, input logic dp_v, input logic fs_v);
        cyc_exp_t e;
        for (int t = 0; t < 16; t++) begin
            logic on;
            on    = (t >= 2) && (t - 2 < lit);
            e.cyc = first + t;
            e.an  = on ? an_v  : 4'hF;
            e.seg = on ? seg_v : 7'h7F;
            e.dp  = on ? dp_v  : 1'b1;
            e.fs  = (t == 0) ? fs_v : 1'b0;
            cq.push_back(e);
        end
    endtask

    task automatic exp_frame(input int base, input int lit,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] bl, input logic [3:0] dpm);
        exp_slot(base + 1,  bl[3] ? 0 : lit, 4'b0111, s3, ~dpm[3], 1'b1);
        exp_slot(base + 17, bl[2] ? 0 : lit, 4'b1011, s2, ~dpm[2], 1'b0);
        exp_slot(base + 33, bl[1] ? 0 : lit, 4'b1101, s1, ~dpm[1], 1'b0);
        exp_slot(base + 49, bl[0] ? 0 : lit, 4'b1110, s0, ~dpm[0], 1'b0);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL %s got an=%b seg=%h dp=%b fs=%b required an=1111 seg=7f dp=1 fs=0",
                     name, an, seg, dp, frame_start);
        end
    endtask

    task automatic enter_reset(input logic [15:0] w, input logic [3:0] b,
                               input logic [3:0] bl, input logic [3:0] dpm);
        @(negedge clk);
        reset  = 1'b1;
        word   = w;
        bright = b;
        blank  = bl;
        dp_in  = dpm;
        #1;
        check_idle("reset_state");
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (cq.size() > 0 || sq.size() > 0); i++) @(negedge clk);
        #1;
        checks++;
        if (cq.size() > 0 || sq.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d required 0", cq.size() + sq.size());
            cq.delete();
            sq.delete();
        end
    endtask

    initial begin
        reset  = 1'b1;
        word   = '0;
        dp_in  = '0;
        blank  = '0;
        bright = '0;
        repeat (2) @(negedge clk);

        // Basic scan, two frames
        enter_reset(16'h12AF, 4'd14, 4'b0000, 4'b0000);
        exp_frame(0,  14, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0000, 4'b0000);
        exp_frame(64, 14, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0000, 4'b0000);
        release_reset();
        wait_drain(300);

        // Brightness: 4, 0 and clamped 15
        enter_reset(16'h12AF, 4'd4, 4'b0000, 4'b0000);
        exp_frame(0, 4, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0000, 4'b0000);
        release_reset();
        wait_drain(200);

        enter_reset(16'h12AF, 4'd0, 4'b0000, 4'b0000);
        exp_frame(0, 0, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0000, 4'b0000);
        release_reset();
        wait_drain(200);

        enter_reset(16'h12AF, 4'd15, 4'b0000, 4'b0000);
        exp_frame(0, 14, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0000, 4'b0000);
        release_reset();
        wait_drain(200);

        // Blank digit 2, decimal point on digit 0
        enter_reset(16'h12AF, 4'd14, 4'b0100, 4'b0001);
        exp_frame(0, 14, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0100, 4'b0001);
        release_reset();
        wait_drain(200);

        // Mid-frame word change waits for the next frame
        enter_reset(16'h1234, 4'd14, 4'b0000, 4'b0000);
        exp_frame(0,  14, 7'h4F, 7'h12, 7'h06, 7'h4C, 4'b0000, 4'b0000);
        exp_frame(64, 14, 7'h24, 7'h20, 7'h0F, 7'h00, 4'b0000, 4'b0000);
        release_reset();
        repeat (20) @(negedge clk);
        word = 16'h5678;
        wait_drain(300);

        // Asynchronous reset while digit 1 is lit
        enter_reset(16'h12AF, 4'd14, 4'b0000, 4'b0000);
        exp_slot(1,  14, 4'b0111, 7'h4F, 1'b1, 1'b1);
        exp_slot(17, 14, 4'b1011, 7'h12, 1'b1, 1'b0);
        release_reset();
        repeat (37) @(negedge clk);
        checks++;
        if (an !== 4'b1101 || seg !== 7'h08) begin
            errors++;
            $display("FAIL pre_reset_digit1 got an=%b seg=%h required an=1101 seg=08", an, seg);
        end
        #2 reset = 1'b1;
        #1 check_idle("async_reset");
        exp_frame(0, 14, 7'h4F, 7'h12, 7'h08, 7'h38, 4'b0000, 4'b0000);
        release_reset();
        wait_drain(200);

        // Random frames: inputs change just before each frame's load edge
        enter_reset(16'h0000, 4'd0, 4'b0000, 4'b0000);
        for (int f = 0; f < 1000; f++) begin
            word   = 16'($urandom);
            bright = 4'($urandom_range(0, 15));
            blank  = 4'($urandom_range(0, 15));
            dp_in  = 4'($urandom_range(0, 15));
            for (int d = 3; d >= 0; d--) begin
                slot_exp_t s;
                s.last = 64 * f + 16 * (3 - d) + 16;
                s.an   = ~(4'b0001 << d);
                s.seg  = tbl[word[4*d +: 4]];
                s.dp   = ~dp_in[d];
                s.lit  = blank[d] ? 0 : ((bright > 4'd14) ? 14 : int'(bright));
                sq.push_back(s);
            end
            if (f == 0) reset = 1'b0;
            repeat (64) @(negedge clk);
        end
        wait_drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
